// File: rtl/kmap_scan_capture.sv
// kmap_scan_capture
//   Stimulus/capture stage for a 4-input combinational K-map function.
//   - Walks {a,b,c,d} through all 16 minterms in Gray-code order.
//   - Waits SETTLE extra cycles per minterm, then samples out_i.
//   - Builds a 16-bit truth table and counts mismatches against an expected
//     table. Only cells whose care_mask bit is 1 are counted.
//
// Ports
//   clk          : rising-edge clock
//   reset        : synchronous, active-high
//   start        : begin a scan; looked at only while idle
//   expected     : expected truth table, bit index = {a,b,c,d}; latched on start
//   care_mask    : 1 = cell checked, 0 = don't-care; latched on start
//   out_i        : output of the function under test
//   a,b,c,d      : minterm drive to the function under test (a = MSB)
//   busy         : high from the cycle after start is accepted through DONE
//   done         : one-cycle pulse when the scan completes
//   table_o      : captured truth table, bit index = {a,b,c,d}
//   mismatch_cnt : number of cared cells where out_i != expected (0..16)
//   pass         : set after a completed scan with zero mismatches
//   dbg_state    : current FSM state (IDLE=0, WAIT=1, SAMPLE=2, DONE=3)
//
// Handshake: start is a level that is accepted on any rising edge where the
// FSM is IDLE. Once accepted, further start pulses are ignored until the FSM
// is back in IDLE. Completion is signalled by a single-cycle done pulse; no
// acknowledge is needed. If start is held high through DONE, the next scan
// begins after exactly one IDLE cycle.
module kmap_scan_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic [15:0] care_mask,
  input  logic        out_i,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_o,
  output logic [4:0]  mismatch_cnt,
  output logic        pass,
  output logic [1:0]  dbg_state
);

  // SETTLE is legal in 0..15, so four bits hold the reload value.
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_step;
  logic [3:0]  r_settle;
  logic [3:0]  r_drive;
  logic [15:0] r_exp;
  logic [15:0] r_care;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_table;
  logic [4:0]  r_cnt;
  logic        r_pass;

  logic [3:0]  w_gray;
  logic [3:0]  w_next_step;
  logic [3:0]  w_next_gray;
  logic        w_miss;

  // Gray code of the current step and of the next step. r_drive always
  // equals w_gray while in WAIT/SAMPLE; w_gray is used for indexing so
  // the sampled cell never depends on the output register.
  assign w_gray      = r_step ^ (r_step >> 1);
  assign w_next_step = r_step + 4'd1;
  assign w_next_gray = w_next_step ^ (w_next_step >> 1);
  assign w_miss      = r_care[w_gray] & (out_i ^ r_exp[w_gray]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_step   <= 4'd0;
      r_settle <= 4'd0;
      r_drive  <= 4'd0;
      r_exp    <= 16'd0;
      r_care   <= 16'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= 16'd0;
      r_cnt    <= 5'd0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_drive <= 4'd0;
          if (start) begin
            r_exp    <= expected;
            r_care   <= care_mask;
            r_step   <= 4'd0;
            r_drive  <= 4'd0;
            r_settle <= SETTLE_L;
            r_table  <= 16'd0;
            r_cnt    <= 5'd0;
            r_pass   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          // SETTLE+1 cycles in WAIT: the counter is loaded with SETTLE and
          // SAMPLE is entered on the edge where it reads zero.
          if (r_settle == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end

        S_SAMPLE: begin
          r_table[w_gray] <= out_i;
          // At most 16 increments, so the 5-bit count cannot wrap.
          if (w_miss) begin
            r_cnt <= r_cnt + 5'd1;
          end
          if (r_step == 4'd15) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_step   <= w_next_step;
            r_drive  <= w_next_gray;
            r_settle <= SETTLE_L;
            r_state  <= S_WAIT;
          end
        end

        S_DONE: begin
          // The last SAMPLE edge already updated r_cnt, so it is final here.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_pass  <= (r_cnt == 5'd0);
          r_drive <= 4'd0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign {a, b, c, d}  = r_drive;
  assign busy          = r_busy;
  assign done          = r_done;
  assign table_o       = r_table;
  assign mismatch_cnt  = r_cnt;
  assign pass          = r_pass;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_kmap_scan_capture.sv
// Bench for kmap_scan_capture: one instance with SETTLE=1 and one with
// SETTLE=0. Each instance drives a behavioural K-map function model.
module tb_kmap_scan_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] expected;
  logic [15:0] care_mask;

  // SETTLE=1 instance
  logic        start1;
  logic [15:0] fut1;
  logic        out1;
  logic        a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] table1;
  logic [4:0]  cnt1;
  logic [1:0]  st1;

  // SETTLE=0 instance
  logic        start0;
  logic [15:0] fut0;
  logic        out0;
  logic        a0, b0, c0, d0, busy0, done0, pass0;
  logic [15:0] table0;
  logic [4:0]  cnt0;
  logic [1:0]  st0;

  // Function-under-test models: a plain lookup on the driven minterm.
  assign out1 = fut1[{a1, b1, c1, d1}];
  assign out0 = fut0[{a0, b0, c0, d0}];

  kmap_scan_capture #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .expected(expected), .care_mask(care_mask), .out_i(out1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .table_o(table1),
    .mismatch_cnt(cnt1), .pass(pass1), .dbg_state(st1)
  );

  kmap_scan_capture #(.SETTLE(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .expected(expected), .care_mask(care_mask), .out_i(out0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .table_o(table0),
    .mismatch_cnt(cnt0), .pass(pass0), .dbg_state(st0)
  );

  // ---------------- scoreboard ----------------
  // Packed as {table[15:0], mismatch_cnt[4:0], pass}.
  logic [21:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] gray_order [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  typedef struct {
    logic [15:0] fut;
    logic [15:0] ex;
    logic [15:0] care;
    logic [15:0] want_table;
    logic [4:0]  want_cnt;
    logic        want_pass;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic pop_check(input string name, input logic [21:0] got);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got 0x%0h, want <scoreboard empty>", name, got);
    end else begin
      check(name, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver: SETTLE=1 scan ----------------
  // poke_n: cycle (after acceptance) at which a one-cycle start is pulsed.
  // rst_n : cycle at which reset is asserted for one edge (0 = none).
  task automatic run1(input vec_t v, input int poke_n, input int rst_n);
    int done_n   = 0;
    int n_done   = 0;
    int busy_bad = 0;
    int busy_end;
    busy_end  = (rst_n != 0) ? rst_n : 49;
    fut1      = v.fut;
    expected  = v.ex;
    care_mask = v.care;
    if (rst_n == 0) exp_q.push_back({v.want_table, v.want_cnt, v.want_pass});
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done1) begin
        n_done++;
        if (done_n == 0) done_n = n;
      end
      if (busy1 !== ((n <= busy_end) ? 1'b1 : 1'b0)) busy_bad++;
      if (n == poke_n) start1 = 1'b1;
      if (n == poke_n + 1) start1 = 1'b0;
      if (rst_n != 0 && n == rst_n) reset = 1'b1;
      if (rst_n != 0 && n == rst_n + 1) begin
        reset = 1'b0;
        check("reset_mid_scan_outputs",
              32'({a1, b1, c1, d1, busy1, done1, table1, cnt1, pass1, st1}), 32'd0);
      end
    end
    check("busy_window", 32'(busy_bad), 32'd0);
    if (rst_n != 0) begin
      check("no_done_after_reset", 32'(n_done), 32'd0);
    end else begin
      check("done_count", 32'(n_done), 32'd1);
      check("done_cycle", 32'(done_n), 32'd49);
      check("abcd_idle", 32'({a1, b1, c1, d1}), 32'd0);
      pop_check("result1", {table1, cnt1, pass1});
    end
  endtask

  // ---------------- driver: SETTLE=0 drive-order scan ----------------
  task automatic run0();
    int done_n = 0;
    logic [3:0] seen [16];
    fut0      = 16'hDD0C;
    expected  = 16'hDD0C;
    care_mask = 16'hDDEF;
    exp_q.push_back({16'hDD0C, 5'd0, 1'b1});
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done0 && done_n == 0) done_n = n;
      if (n <= 32) begin
        check($sformatf("drive_order_n%0d", n), 32'({a0, b0, c0, d0}),
              32'(gray_order[(n - 1) / 2]));
        if (n % 2 == 1) seen[(n - 1) / 2] = {a0, b0, c0, d0};
      end
      if (n == 34) check("abcd_back_to_zero", 32'({a0, b0, c0, d0}), 32'd0);
    end
    for (int s = 1; s < 16; s++) begin
      check($sformatf("one_bit_toggle_s%0d", s), 32'($countones(seen[s] ^ seen[s - 1])), 32'd1);
    end
    check("done_cycle_settle0", 32'(done_n), 32'd33);
    pop_check("result0", {table0, cnt0, pass0});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    start1    = 1'b0;
    start0    = 1'b0;
    expected  = 16'h0;
    care_mask = 16'h0;
    fut1      = 16'h0;
    fut0      = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state_dut1",
          32'({a1, b1, c1, d1, busy1, done1, table1, cnt1, pass1, st1}), 32'd0);
    check("reset_state_dut0",
          32'({a0, b0, c0, d0, busy0, done0, table0, cnt0, pass0, st0}), 32'd0);

    // Vector table: reference function, don't-care tolerance, stuck-at-0
    // fault, mismatch-count maximum, all-don't-care, then random tables.
    vecs[0] = '{16'hDD0C, 16'hDD0C, 16'hDDEF, 16'hDD0C, 5'd0,  1'b1};
    vecs[1] = '{16'hFF1C, 16'hDD0C, 16'hDDEF, 16'hFF1C, 5'd0,  1'b1};
    vecs[2] = '{16'h0000, 16'hDD0C, 16'hDDEF, 16'h0000, 5'd8,  1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 5'd0,  1'b1};
    for (int i = 5; i < 8; i++) begin
      vecs[i].fut        = 16'($urandom_range(0, 65535));
      vecs[i].ex         = 16'($urandom_range(0, 65535));
      vecs[i].care       = 16'($urandom_range(0, 65535));
      vecs[i].want_table = vecs[i].fut;
      vecs[i].want_cnt   = 5'($countones((vecs[i].fut ^ vecs[i].ex) & vecs[i].care));
      vecs[i].want_pass  = (vecs[i].want_cnt == 5'd0);
    end

    for (int i = 0; i < 8; i++) run1(vecs[i], 0, 0);

    // Drive order and timing at SETTLE=0.
    run0();

    // start pulsed during WAIT at step 3 must be ignored.
    run1(vecs[2], 10, 0);

    // Reset in WAIT at step 7, then a fresh scan completes normally.
    run1(vecs[0], 0, 23);
    run1(vecs[1], 0, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
